// File: rtl/up_counter_3bit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : up_counter_3bit_ctrl_if
// Description : Control/status bundle between a sequencer client and the
//               up_counter_3bit_ctrl block.
// Revision    : 1.0 - initial release
// ============================================================================
interface up_counter_3bit_ctrl_if #(
    parameter int WIDTH  = 3,
    parameter int PASS_W = 4
);
    logic              start;
    logic [WIDTH-1:0]  length;
    logic [PASS_W-1:0] repeats;
    logic              hold;
    logic              abort;
    logic              auto_reload;
    logic [WIDTH-1:0]  count;
    logic [PASS_W-1:0] pass_idx;
    logic              busy;
    logic              done;

    modport master (
        output start, length, repeats, hold, abort, auto_reload,
        input  count, pass_idx, busy, done
    );

    modport slave (
        input  start, length, repeats, hold, abort, auto_reload,
        output count, pass_idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/up_counter_3bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : up_counter_3bit_ctrl
// Description : Programmable multi-pass up-counter sequencer with hold,
//               abort, auto-reload and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module up_counter_3bit_ctrl #(
    parameter int WIDTH  = 3,
    parameter int PASS_W = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    up_counter_3bit_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_count;
    logic [PASS_W-1:0] r_pass;
    logic [WIDTH-1:0]  r_len;
    logic [PASS_W-1:0] r_reps;
    logic              r_busy;
    logic              r_done;

    logic [PASS_W:0]   w_pass_next;
    logic              w_more_passes;

    // Extra bit keeps pass_idx+1 from wrapping when compared against reps.
    assign w_pass_next   = {1'b0, r_pass} + (PASS_W+1)'(1);
    assign w_more_passes = (w_pass_next < {1'b0, r_reps});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_pass  <= '0;
            r_len   <= '0;
            r_reps  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    r_pass  <= '0;
                    if (bus.start && !bus.abort) begin
                        r_len   <= bus.length;
                        r_reps  <= (bus.repeats == '0) ? PASS_W'(1) : bus.repeats;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_pass  <= '0;
                        r_busy  <= 1'b0;
                    end else if (bus.hold) begin
                        r_state <= HOLD;
                    end else if (r_count < r_len) begin
                        r_count <= r_count + WIDTH'(1);
                    end else if (w_more_passes) begin
                        r_count <= '0;
                        r_pass  <= w_pass_next[PASS_W-1:0];
                    end else begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                HOLD: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_pass  <= '0;
                        r_busy  <= 1'b0;
                    end else if (!bus.hold) begin
                        r_state <= RUN;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_count <= '0;
                    r_pass  <= '0;
                    if (!bus.abort && bus.auto_reload) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_pass  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count    = r_count;
    assign bus.pass_idx = r_pass;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_up_counter_3bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_up_counter_3bit_ctrl
// Description : Directed and randomized bench for up_counter_3bit_ctrl,
//               compared each cycle against a run-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_counter_3bit_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    up_counter_3bit_ctrl_if #(.WIDTH(3), .PASS_W(4)) bus ();

    up_counter_3bit_ctrl #(.WIDTH(3), .PASS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the run is a position j along reps*(len+1) run cycles.
    int m_mode;   // 0 idle, 1 running, 2 held, 3 done
    int m_j;
    int m_len;
    int m_reps;

    function automatic void m_reset();
        m_mode = 0; m_j = 0; m_len = 0; m_reps = 0;
    endfunction

    task automatic m_edge();
        case (m_mode)
            0: if (bus.start && !bus.abort) begin
                   m_len  = int'(bus.length);
                   m_reps = (bus.repeats == 0) ? 1 : int'(bus.repeats);
                   m_j    = 0;
                   m_mode = 1;
               end
            1: if (bus.abort)      m_mode = 0;
               else if (bus.hold)  m_mode = 2;
               else begin
                   m_j++;
                   if (m_j == m_reps * (m_len + 1)) m_mode = 3;
               end
            2: if (bus.abort)      m_mode = 0;
               else if (!bus.hold) m_mode = 1;
            default: if (!bus.abort && bus.auto_reload) begin
                         m_j = 0; m_mode = 1;
                     end else m_mode = 0;
        endcase
    endtask

    task automatic compare(input string tag);
        int ec, ep, eb, ed;
        case (m_mode)
            0:       begin ec = 0; ep = 0; eb = 0; ed = 0; end
            3:       begin ec = m_len; ep = m_reps - 1; eb = 0; ed = 1; end
            default: begin
                ec = m_j % (m_len + 1);
                ep = m_j / (m_len + 1);
                eb = 1; ed = 0;
            end
        endcase
        chk({tag, ".count"}, 32'(bus.count),    ec);
        chk({tag, ".pass"},  32'(bus.pass_idx), ep);
        chk({tag, ".busy"},  32'(bus.busy),     eb);
        chk({tag, ".done"},  32'(bus.done),     ed);
    endtask

    task automatic step(input string tag, input logic s, input int l, input int r,
                        input logic h, input logic a, input logic ar);
        @(negedge clk);
        bus.start       = s;
        bus.length      = 3'(l);
        bus.repeats     = 4'(r);
        bus.hold        = h;
        bus.abort       = a;
        bus.auto_reload = ar;
        @(posedge clk);
        m_edge();
        #1;
        compare(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.length = '0; bus.repeats = '0;
        bus.hold = 1'b0; bus.abort = 1'b0; bus.auto_reload = 1'b0;
        m_reset();
        #2;
        compare("reset");
        @(negedge clk);
        rst = 1'b1;
        idle_steps("idle", 2);

        // Reset asserted mid-pass at count=5, between clock edges.
        step("rst_run", 1'b1, 7, 1, 1'b0, 1'b0, 1'b0);
        idle_steps("rst_run", 5);
        #2 rst = 1'b0;
        #1 m_reset();
        compare("async_rst");
        @(negedge clk);
        rst = 1'b1;
        idle_steps("post_rst", 3);

        // Single pass to 7, then return to idle.
        step("single", 1'b1, 7, 1, 1'b0, 1'b0, 1'b0);
        idle_steps("single", 10);

        // Three passes of length 2; then repeats=0 acting as one pass.
        step("multi", 1'b1, 2, 3, 1'b0, 1'b0, 1'b0);
        idle_steps("multi", 11);
        step("rep0", 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
        idle_steps("rep0", 5);

        // Hold at count=2 for three cycles with a start attempt inside.
        step("hold", 1'b1, 4, 1, 1'b0, 1'b0, 1'b0);
        idle_steps("hold", 2);
        step("hold", 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        step("hold", 1'b1, 1, 1, 1'b1, 1'b0, 1'b0);
        step("hold", 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        idle_steps("hold", 6);

        // Abort at count=3 in pass 1, and abort from HOLD.
        step("abort", 1'b1, 4, 3, 1'b0, 1'b0, 1'b0);
        idle_steps("abort", 8);
        step("abort", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle_steps("abort", 2);
        step("abort_h", 1'b1, 4, 3, 1'b0, 1'b0, 1'b0);
        step("abort_h", 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        step("abort_h", 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        idle_steps("abort_h", 2);

        // start together with abort in IDLE is refused.
        step("st_ab", 1'b1, 3, 1, 1'b0, 1'b1, 1'b0);
        idle_steps("st_ab", 1);

        // Auto-reload with length 0, two passes, then drop auto_reload.
        step("reload", 1'b1, 0, 2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step("reload", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle_steps("reload", 4);

        for (int i = 0; i < 1500; i++) begin
            step("rand",
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 4)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
